// File: rtl/tri_bbox_walker_if.sv
// Triangle-in / pixel-out handshake bundle for tri_bbox_walker.
// master = upstream clipper + downstream consumer side, slave = walker.
interface tri_bbox_walker_if #(
  parameter int COORD_W = 12
);
  logic signed [47:0] FX1;
  logic signed [47:0] FY1;
  logic signed [47:0] FX2;
  logic signed [47:0] FY2;
  logic signed [47:0] FX3;
  logic signed [47:0] FY3;
  logic               triangle_visible;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic               out_last;

  modport master (
    output FX1, FY1, FX2, FY2, FX3, FY3,
    output triangle_visible, in_valid, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_last
  );

  modport slave (
    input  FX1, FY1, FX2, FY2, FX3, FY3,
    input  triangle_visible, in_valid, out_ready,
    output in_ready, out_valid, out_x, out_y, out_last
  );
endinterface

// File: rtl/tri_bbox_walker.sv
// Clamped integer bounding box of a clipped triangle,
// emitted pixel by pixel in raster order.
module tri_bbox_walker #(
  parameter int COORD_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        FRAC_BITS,
  input  logic [31:0]       max_width,
  input  logic [31:0]       max_height,
  tri_bbox_walker_if.slave  bus,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WALK  = 2'd2;

  logic [1:0] state;

  logic signed [47:0] fx1, fx2, fx3;
  logic signed [47:0] fy1, fy2, fy3;

  logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic [COORD_W-1:0] cxmin, cxmax, cymin, cymax;
  logic signed [47:0] sxmin, sxmax, symin, symax;
  logic drop;

  function automatic logic signed [47:0] min3(
    input logic signed [47:0] a,
    input logic signed [47:0] b,
    input logic signed [47:0] c
  );
    logic signed [47:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [47:0] max3(
    input logic signed [47:0] a,
    input logic signed [47:0] b,
    input logic signed [47:0] c
  );
    logic signed [47:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Clamp a floored pixel index into [0, lim-1]; lim is never 0 here.
  function automatic logic [COORD_W-1:0] clamp(
    input logic signed [47:0] v,
    input logic [31:0]        lim
  );
    logic signed [48:0] hi;
    logic signed [48:0] w;
    hi = $signed({17'd0, lim}) - 49'sd1;
    w  = {v[47], v};
    if (w < 49'sd0)
      w = 49'sd0;
    else if (w > hi)
      w = hi;
    return w[COORD_W-1:0];
  endfunction

  // Bounding box of the registered vertices, floored and clamped.
  always_comb begin
    sxmin = min3(fx1, fx2, fx3) >>> FRAC_BITS;
    sxmax = max3(fx1, fx2, fx3) >>> FRAC_BITS;
    symin = min3(fy1, fy2, fy3) >>> FRAC_BITS;
    symax = max3(fy1, fy2, fy3) >>> FRAC_BITS;
    cxmin = clamp(sxmin, max_width);
    cxmax = clamp(sxmax, max_width);
    cymin = clamp(symin, max_height);
    cymax = clamp(symax, max_height);
    drop  = !bus.triangle_visible
          || (max_width == 32'd0)
          || (max_height == 32'd0);
  end

  // Accept, set up the box, then step the raster cursor.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.out_x    <= '0;
      bus.out_y    <= '0;
      busy         <= 1'b0;
      drop_count   <= '0;
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
      fx1 <= '0;
      fx2 <= '0;
      fx3 <= '0;
      fy1 <= '0;
      fy2 <= '0;
      fy3 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            fx1 <= bus.FX1;
            fx2 <= bus.FX2;
            fx3 <= bus.FX3;
            fy1 <= bus.FY1;
            fy2 <= bus.FY2;
            fy3 <= bus.FY3;
            if (drop) begin
              if (drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
            end else begin
              state        <= SETUP;
              bus.in_ready <= 1'b0;
              busy         <= 1'b1;
            end
          end
        end
        SETUP: begin
          xmin <= cxmin;
          xmax <= cxmax;
          ymin <= cymin;
          ymax <= cymax;
          bus.out_x <= cxmin;
          bus.out_y <= cymin;
          bus.out_last <= (cxmin == cxmax)
                       && (cymin == cymax);
          bus.out_valid <= 1'b1;
          state <= WALK;
        end
        WALK: begin
          if (bus.out_ready) begin
            if (bus.out_x < xmax) begin
              bus.out_x <= bus.out_x + COORD_W'(1);
              bus.out_last <= (bus.out_x + COORD_W'(1) == xmax)
                           && (bus.out_y == ymax);
            end else if (bus.out_y < ymax) begin
              bus.out_x <= xmin;
              bus.out_y <= bus.out_y + COORD_W'(1);
              bus.out_last <= (xmin == xmax)
                           && (bus.out_y + COORD_W'(1) == ymax);
            end else begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.in_ready  <= 1'b1;
              busy          <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bbox_walker.sv
// Directed + randomized bench for tri_bbox_walker against a
// bounding-box enumeration model.
module tb_tri_bbox_walker;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  frac;
  logic [31:0] mw;
  logic [31:0] mh;
  logic        busy;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  tri_bbox_walker_if #(.COORD_W(12)) bus();

  tri_bbox_walker #(
    .COORD_W(12),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .FRAC_BITS(frac),
    .max_width(mw),
    .max_height(mh),
    .bus(bus.slave),
    .busy(busy),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint x;
    longint y;
    bit     last;
  } pix_t;

  pix_t   expq[$];
  longint vx[3];
  longint vy[3];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every integer pixel of the clamped box, row by row.
  task automatic model();
    longint xl, xh, yl, yh;
    pix_t p;
    xl = vx[0]; xh = vx[0];
    yl = vy[0]; yh = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < xl) xl = vx[i];
      if (vx[i] > xh) xh = vx[i];
      if (vy[i] < yl) yl = vy[i];
      if (vy[i] > yh) yh = vy[i];
    end
    xl = xl >>> frac; xh = xh >>> frac;
    yl = yl >>> frac; yh = yh >>> frac;
    if (xl < 0) xl = 0;
    if (xh < 0) xh = 0;
    if (yl < 0) yl = 0;
    if (yh < 0) yh = 0;
    if (xl > longint'(mw) - 1) xl = longint'(mw) - 1;
    if (xh > longint'(mw) - 1) xh = longint'(mw) - 1;
    if (yl > longint'(mh) - 1) yl = longint'(mh) - 1;
    if (yh > longint'(mh) - 1) yh = longint'(mh) - 1;
    expq.delete();
    for (longint y = yl; y <= yh; y++)
      for (longint x = xl; x <= xh; x++) begin
        p.x = x;
        p.y = y;
        p.last = (x == xh) && (y == yh);
        expq.push_back(p);
      end
  endtask

  task automatic apply_tri(bit vis);
    bus.FX1 = 48'(vx[0]);
    bus.FX2 = 48'(vx[1]);
    bus.FX3 = 48'(vx[2]);
    bus.FY1 = 48'(vy[0]);
    bus.FY2 = 48'(vy[1]);
    bus.FY3 = 48'(vy[2]);
    bus.triangle_visible = vis;
    bus.in_valid = 1'b1;
  endtask

  task automatic set_tri(longint x0, longint y0, longint x1,
                         longint y1, longint x2, longint y2);
    vx[0] = x0; vy[0] = y0;
    vx[1] = x1; vy[1] = y1;
    vx[2] = x2; vy[2] = y2;
  endtask

  task automatic walk(string name, bit rnd);
    int idx;
    int cyc;
    bit stalled;
    logic [11:0] hx, hy;
    logic hl;
    model();
    apply_tri(1'b1);
    chk({name, " in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({name, " setup_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({name, " setup_busy"}, 64'(busy), 64'd1);
    chk({name, " setup_valid"}, 64'(bus.out_valid), 64'd0);
    tick();
    chk({name, " first_valid"}, 64'(bus.out_valid), 64'd1);
    idx = 0;
    cyc = 0;
    while (idx < expq.size() && cyc < 5000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = bus.out_valid && !bus.out_ready;
      hx = bus.out_x;
      hy = bus.out_y;
      hl = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("%s x[%0d]", name, idx), 64'(bus.out_x), 64'(expq[idx].x));
        chk($sformatf("%s y[%0d]", name, idx), 64'(bus.out_y), 64'(expq[idx].y));
        chk($sformatf("%s last[%0d]", name, idx), 64'(bus.out_last), 64'(expq[idx].last));
        idx++;
      end
      tick();
      cyc++;
      if (stalled) begin
        chk({name, " hold_x"}, 64'(bus.out_x), 64'(hx));
        chk({name, " hold_y"}, 64'(bus.out_y), 64'(hy));
        chk({name, " hold_last"}, 64'(bus.out_last), 64'(hl));
      end
    end
    chk({name, " pixel_count"}, 64'(idx), 64'(expq.size()));
    chk({name, " done_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({name, " done_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, " done_busy"}, 64'(busy), 64'd0);
    chk({name, " done_last"}, 64'(bus.out_last), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frac = 8'd4;
    mw = 32'd640;
    mh = 32'd480;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.triangle_visible = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0);
    apply_tri(1'b0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_last", 64'(bus.out_last), 64'd0);
    chk("rst out_x", 64'(bus.out_x), 64'd0);
    chk("rst out_y", 64'(bus.out_y), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst drop", 64'(drop_count), 64'd0);

    // basic
    set_tri(24, 36, 48, 32, 32, 76);
    walk("basic", 1'b0);

    // three invisible triangles back to back
    set_tri(24, 36, 48, 32, 32, 76);
    apply_tri(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drop in_ready[%0d]", i), 64'(bus.in_ready), 64'd1);
      tick();
      chk($sformatf("drop count[%0d]", i), 64'(drop_count), 64'(i + 1));
      chk($sformatf("drop valid[%0d]", i), 64'(bus.out_valid), 64'd0);
    end
    // zero-width render area
    mw = 32'd0;
    apply_tri(1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("zero_w drop", 64'(drop_count), 64'd4);
    chk("zero_w valid", 64'(bus.out_valid), 64'd0);
    chk("zero_w busy", 64'(busy), 64'd0);
    mw = 32'd640;

    // clamp at right edge
    frac = 8'd8;
    set_tri(638 * 256, 0, 640 * 256, 0, 640 * 256, 256);
    walk("clamp", 1'b0);
    chk("clamp size", 64'(expq.size()), 64'd4);

    // backpressure
    frac = 8'd4;
    set_tri(24, 36, 48, 32, 32, 76);
    walk("bp", 1'b1);

    // single pixel
    set_tri(81, 113, 94, 120, 88, 127);
    walk("single", 1'b0);

    // reset after four pixels
    set_tri(24, 36, 48, 32, 32, 76);
    model();
    apply_tri(1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rmw x[%0d]", i), 64'(bus.out_x), 64'(expq[i].x));
      chk($sformatf("rmw y[%0d]", i), 64'(bus.out_y), 64'(expq[i].y));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    chk("rmw out_valid", 64'(bus.out_valid), 64'd0);
    chk("rmw busy", 64'(busy), 64'd0);
    chk("rmw drop", 64'(drop_count), 64'd0);
    chk("rmw in_ready", 64'(bus.in_ready), 64'd1);
    chk("rmw out_last", 64'(bus.out_last), 64'd0);
    set_tri(100, 40, 130, 70, 110, 50);
    walk("after_rst", 1'b0);

    // random triangles, small render areas, negative coords
    for (int t = 0; t < 6; t++) begin
      frac = 8'd4;
      mw = 32'($urandom_range(8, 24));
      mh = 32'($urandom_range(6, 16));
      for (int i = 0; i < 3; i++) begin
        vx[i] = longint'($urandom_range(0, 480)) - 64;
        vy[i] = longint'($urandom_range(0, 320)) - 64;
      end
      walk($sformatf("rand%0d", t), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
